// File: rtl/axis_buf_pkg.sv
// Shared types and constants for the ping-pong AXI-Stream frame buffer.
package axis_buf_pkg;

  typedef enum logic [2:0] {
    EMPTY,
    FILLING,
    FULL,
    SENDING,
    WAIT_DONE
  } bank_state_t;

  localparam int NUM_BANKS   = 2;
  localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/axis_buf_bank_ram.sv
// Simple dual-port RAM with one write port and one registered, enabled read port.
// Read data resets to zero and holds while re is low, so it can drive an output directly.
module axis_buf_bank_ram #(
  parameter int DATA_W = 36,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axis_pingpong_frame_buffer.sv
// Two-bank AXI-Stream frame buffer: one bank captures while the other replays; tvalid 2 cycles after close.
// S_AXIS_tready drops only while both banks hold closed frames; M side holds its beat until handshake.
module axis_pingpong_frame_buffer
  import axis_buf_pkg::*;
#(
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int FRAME_LEN          = 256,
  parameter bit TX_DONE_RELEASE    = 1'b1
) (
  input  logic                            axis_aclk,
  input  logic                            axis_aresetn,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   S_AXIS_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_tstrb,
  input  logic                            S_AXIS_tlast,
  input  logic                            S_AXIS_tvalid,
  output logic                            S_AXIS_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   M_AXIS_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_tstrb,
  output logic                            M_AXIS_tlast,
  output logic                            M_AXIS_tvalid,
  input  logic                            M_AXIS_tready,
  input  logic                            tx_done,
  output logic [FRAME_CNT_W-1:0]          frame_count
);

  localparam int ADDR_W = $clog2(FRAME_LEN);
  localparam int STRB_W = C_AXIS_TDATA_WIDTH / 8;
  localparam int WORD_W = C_AXIS_TDATA_WIDTH + STRB_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W + 1)'(1);

  bank_state_t            state_q [NUM_BANKS];
  bank_state_t            state_d [NUM_BANKS];
  logic [ADDR_W:0]        len_q   [NUM_BANKS];
  logic [ADDR_W:0]        len_d   [NUM_BANKS];
  logic                   wr_bank_q, wr_bank_d;
  logic [ADDR_W-1:0]      wr_cnt_q, wr_cnt_d;
  logic                   rd_bank_q, rd_bank_d;
  logic [ADDR_W:0]        rd_cnt_q, rd_cnt_d;
  logic                   out_vld_q, out_vld_d;
  logic                   out_last_q, out_last_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  bank_state_t     rd_state;
  logic            wr_fire, wr_close, m_fire, rd_fetch, rd_release;
  logic [WORD_W-1:0] ram_rdata;

  assign rd_state      = state_q[rd_bank_q];
  assign S_AXIS_tready = axis_aresetn &&
                         (state_q[wr_bank_q] == EMPTY || state_q[wr_bank_q] == FILLING);
  assign wr_fire       = S_AXIS_tvalid && S_AXIS_tready;
  assign wr_close      = wr_fire && (wr_cnt_q == LAST_ADDR || S_AXIS_tlast);
  assign m_fire        = out_vld_q && M_AXIS_tready;

  // Fetch the next word whenever the output register is empty or being emptied this cycle.
  assign rd_fetch   = (rd_state == SENDING) && (rd_cnt_q < len_q[rd_bank_q]) &&
                      (!out_vld_q || M_AXIS_tready);
  assign rd_release = (rd_state == SENDING && m_fire && out_last_q && !TX_DONE_RELEASE) ||
                      (rd_state == WAIT_DONE && tx_done);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    wr_bank_d   = wr_bank_q;
    wr_cnt_d    = wr_cnt_q;
    rd_bank_d   = rd_bank_q;
    rd_cnt_d    = rd_cnt_q;
    out_vld_d   = out_vld_q;
    out_last_d  = out_last_q;
    frame_cnt_d = frame_cnt_q;

    // Write side only touches EMPTY/FILLING banks, read side only the others: never the same bank.
    if (wr_fire) begin
      if (wr_close) begin
        state_d[wr_bank_q] = FULL;
        len_d[wr_bank_q]   = {1'b0, wr_cnt_q} + LEN_ONE;
        wr_cnt_d           = '0;
        wr_bank_d          = ~wr_bank_q;
      end else begin
        state_d[wr_bank_q] = FILLING;
        wr_cnt_d           = wr_cnt_q + ADDR_W'(1);
      end
    end

    case (rd_state)
      FULL: begin
        state_d[rd_bank_q] = SENDING;
        rd_cnt_d           = '0;
      end
      SENDING: begin
        if (m_fire && out_last_q && TX_DONE_RELEASE) state_d[rd_bank_q] = WAIT_DONE;
      end
      default: ;
    endcase

    if (rd_release) begin
      state_d[rd_bank_q] = EMPTY;
      frame_cnt_d        = frame_cnt_q + FRAME_CNT_W'(1);
      rd_bank_d          = ~rd_bank_q;
    end

    if (rd_fetch) begin
      out_vld_d  = 1'b1;
      out_last_d = (rd_cnt_q == len_q[rd_bank_q] - LEN_ONE);
      rd_cnt_d   = rd_cnt_q + LEN_ONE;
    end else if (m_fire) begin
      out_vld_d  = 1'b0;
      out_last_d = 1'b0;
    end
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        state_q[b] <= EMPTY;
        len_q[b]   <= '0;
      end
      wr_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      rd_bank_q   <= 1'b0;
      rd_cnt_q    <= '0;
      out_vld_q   <= 1'b0;
      out_last_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        state_q[b] <= state_d[b];
        len_q[b]   <= len_d[b];
      end
      wr_bank_q   <= wr_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_bank_q   <= rd_bank_d;
      rd_cnt_q    <= rd_cnt_d;
      out_vld_q   <= out_vld_d;
      out_last_q  <= out_last_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Bank select is the address MSB of a single shared RAM.
  axis_buf_bank_ram #(
    .DATA_W (WORD_W),
    .ADDR_W (ADDR_W + 1)
  ) u_ram (
    .clk   (axis_aclk),
    .rst_n (axis_aresetn),
    .we    (wr_fire),
    .waddr ({wr_bank_q, wr_cnt_q}),
    .wdata ({S_AXIS_tstrb, S_AXIS_tdata}),
    .re    (rd_fetch),
    .raddr ({rd_bank_q, rd_cnt_q[ADDR_W-1:0]}),
    .rdata (ram_rdata)
  );

  assign M_AXIS_tdata  = ram_rdata[C_AXIS_TDATA_WIDTH-1:0];
  assign M_AXIS_tstrb  = ram_rdata[WORD_W-1:C_AXIS_TDATA_WIDTH];
  assign M_AXIS_tvalid = out_vld_q;
  assign M_AXIS_tlast  = out_vld_q && out_last_q;
  assign frame_count   = frame_cnt_q;

endmodule

// File: tb/tb_axis_pingpong_frame_buffer.sv
// Bench: two buffers (release on last beat / release on tx_done) against a frame-queue model.
module tb_axis_pingpong_frame_buffer;

  localparam int W  = 32;
  localparam int SW = 4;
  localparam int FL = 4;

  typedef struct packed {
    logic [W-1:0]  d;
    logic [SW-1:0] s;
    logic          l;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [W-1:0]  s_tdata  [2];
  logic [SW-1:0] s_tstrb  [2];
  logic          s_tlast  [2];
  logic          s_tvalid [2];
  logic          s_tready [2];
  logic [W-1:0]  m_tdata  [2];
  logic [SW-1:0] m_tstrb  [2];
  logic          m_tlast  [2];
  logic          m_tvalid [2];
  logic          m_tready [2];
  logic          tx_done  [2];
  logic [15:0]   fcnt     [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output beats and handshake cycles of the release-on-last-beat instance.
  beat_t log_b[$];
  int    log_c[$];
  int    close_cyc = -1;
  int    first_vld = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam bit REL = (g == 1);

    axis_pingpong_frame_buffer #(
      .C_AXIS_TDATA_WIDTH (W),
      .FRAME_LEN          (FL),
      .TX_DONE_RELEASE    (REL)
    ) u_dut (
      .axis_aclk     (clk),
      .axis_aresetn  (rst_n),
      .S_AXIS_tdata  (s_tdata[g]),
      .S_AXIS_tstrb  (s_tstrb[g]),
      .S_AXIS_tlast  (s_tlast[g]),
      .S_AXIS_tvalid (s_tvalid[g]),
      .S_AXIS_tready (s_tready[g]),
      .M_AXIS_tdata  (m_tdata[g]),
      .M_AXIS_tstrb  (m_tstrb[g]),
      .M_AXIS_tlast  (m_tlast[g]),
      .M_AXIS_tvalid (m_tvalid[g]),
      .M_AXIS_tready (m_tready[g]),
      .tx_done       (tx_done[g]),
      .frame_count   (fcnt[g])
    );

    // Model: closed frames queue up as expected beats; a bank is held from close until release.
    beat_t exp_q[$];
    beat_t part_q[$];
    int    unrel   = 0;
    int    rel_cnt = 0;
    bit    waiting = 0;
    bit    prev_stall = 0;
    beat_t prev_beat;

    always @(negedge clk) begin
      beat_t cur, b;
      bit    rdy_exp, close;
      cur = {m_tdata[g], m_tstrb[g], m_tlast[g]};
      if (!rst_n) begin
        exp_q.delete();
        part_q.delete();
        unrel = 0; rel_cnt = 0; waiting = 0; prev_stall = 0;
        if (g == 0) begin
          log_b.delete(); log_c.delete();
          close_cyc = -1; first_vld = -1;
        end
      end else begin
        rdy_exp = (unrel < 2);
        check("s_tready", s_tready[g], rdy_exp);
        check("frame_count", fcnt[g], 16'(rel_cnt));
        if (exp_q.size() == 0) check("tvalid_idle", m_tvalid[g], 1'b0);
        if (prev_stall) check("hold_beat", {m_tvalid[g], cur}, {1'b1, prev_beat});
        if (g == 0 && m_tvalid[g] && first_vld < 0) first_vld = cyc;
        if (waiting && tx_done[g]) begin
          waiting = 0; rel_cnt++; unrel--;
        end
        if (m_tvalid[g] && m_tready[g] && exp_q.size() != 0) begin
          b = exp_q.pop_front();
          check("out_beat", cur, b);
          if (g == 0) begin
            log_b.push_back(cur);
            log_c.push_back(cyc);
          end
          if (b.l) begin
            if (REL) waiting = 1;
            else begin rel_cnt++; unrel--; end
          end
        end
        prev_stall = m_tvalid[g] && !m_tready[g];
        prev_beat  = cur;
        if (s_tvalid[g] && rdy_exp) begin
          close = (part_q.size() == FL - 1) || s_tlast[g];
          part_q.push_back(beat_t'({s_tdata[g], s_tstrb[g], close}));
          if (close) begin
            foreach (part_q[i]) exp_q.push_back(part_q[i]);
            part_q.delete();
            unrel++;
            // Recorded as the edge that accepts the closing beat.
            if (g == 0 && close_cyc < 0) close_cyc = cyc + 1;
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic [W-1:0] d, input logic [SW-1:0] s, input logic l);
    int n = 0;
    s_tdata[i] = d; s_tstrb[i] = s; s_tlast[i] = l; s_tvalid[i] = 1'b1;
    forever begin
      @(negedge clk);
      if (s_tready[i]) break;
      if (++n > 50) begin
        check("send_timeout", s_tready[i], 1'b1);
        s_tvalid[i] = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    s_tvalid[i] = 1'b0;
  endtask

  task automatic check_zero(input int i);
    check("rst_tvalid", m_tvalid[i], 1'b0);
    check("rst_tlast",  m_tlast[i],  1'b0);
    check("rst_tdata",  m_tdata[i],  '0);
    check("rst_tstrb",  m_tstrb[i],  '0);
    check("rst_fcnt",   fcnt[i],     '0);
    check("rst_tready", s_tready[i], 1'b0);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int k;
    bit acc;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_tdata[i] = '0; s_tstrb[i] = '0; s_tlast[i] = 1'b0; s_tvalid[i] = 1'b0;
      m_tready[i] = 1'b0; tx_done[i] = 1'b0;
    end
    #1;
    check_zero(0);
    check_zero(1);
    idle(3);
    rst_n = 1'b1;
    #1;
    check("rel_tready0", s_tready[0], 1'b1);
    check("rel_tready1", s_tready[1], 1'b1);

    // Continuous 1..8, strobe 0011 on beat 3.
    m_tready[0] = 1'b1;
    for (int i = 1; i <= 8; i++) send(0, W'(i), (i == 3) ? 4'b0011 : 4'hF, 1'b0);
    idle(12);
    check("first_vld_latency", first_vld - close_cyc, 2);
    check("fcnt_after_8", fcnt[0], 16'd2);
    check("log0", log_b[0], {32'h1, 4'hF, 1'b0});
    check("log2_strb", log_b[2], {32'h3, 4'b0011, 1'b0});
    check("log3_last", log_b[3], {32'h4, 4'hF, 1'b1});
    check("log7_last", log_b[7], {32'h8, 4'hF, 1'b1});

    // Short frame followed by a full one.
    send(0, 32'hA, 4'hF, 1'b0);
    send(0, 32'hB, 4'hF, 1'b1);
    for (int i = 0; i < 4; i++) send(0, 32'h10 + W'(i), 4'hF, 1'b0);
    idle(12);
    check("short_a", log_b[8], {32'hA, 4'hF, 1'b0});
    check("short_b", log_b[9], {32'hB, 4'hF, 1'b1});
    check("after_short", log_b[13], {32'h13, 4'hF, 1'b1});
    check("fcnt_after_short", fcnt[0], 16'd4);

    // Backpressure: 12 offered, 8 fit.
    m_tready[0] = 1'b0;
    k = 0;
    s_tdata[0] = 32'h100; s_tstrb[0] = 4'hF; s_tlast[0] = 1'b0; s_tvalid[0] = 1'b1;
    repeat (20) begin
      @(negedge clk);
      acc = s_tready[0] && s_tvalid[0];
      @(posedge clk); #1;
      if (acc) begin k++; s_tdata[0] = 32'h100 + W'(k); end
      if (k == 12) s_tvalid[0] = 1'b0;
    end
    s_tvalid[0] = 1'b0;
    check("bp_accepted", k, 8);
    check("bp_tready", s_tready[0], 1'b0);
    m_tready[0] = 1'b1;
    idle(20);
    check("bp_first", log_b[14], {32'h100, 4'hF, 1'b0});
    check("bp_last", log_b[21], {32'h107, 4'hF, 1'b1});
    check("bp_gapless_a", log_c[17] - log_c[14], 3);
    check("bp_gapless_b", log_c[21] - log_c[18], 3);
    check("fcnt_after_bp", fcnt[0], 16'd6);

    // Release on tx_done.
    m_tready[1] = 1'b1;
    for (int i = 0; i < 4; i++) send(1, 32'h20 + W'(i), 4'hF, 1'b0);
    idle(20);
    check("txd_hold_fcnt", fcnt[1], 16'd0);
    for (int i = 0; i < 4; i++) send(1, 32'h30 + W'(i), 4'hF, 1'b0);
    idle(3);
    @(negedge clk);
    check("txd_both_held", s_tready[1], 1'b0);
    @(posedge clk); #1;
    tx_done[1] = 1'b1;
    @(posedge clk); #1;
    tx_done[1] = 1'b0;
    @(negedge clk);
    check("txd_fcnt1", fcnt[1], 16'd1);
    check("txd_writable", s_tready[1], 1'b1);
    seen = 1'b0;
    for (int n = 0; n < 30 && !seen; n++) begin
      @(negedge clk);
      if (m_tvalid[1] && m_tlast[1] && m_tready[1]) begin
        seen = 1'b1;
        tx_done[1] = 1'b1;
        @(posedge clk); #1;
        tx_done[1] = 1'b0;
      end
    end
    check("txd_last_seen", seen, 1'b1);
    idle(5);
    check("txd_early_ignored", fcnt[1], 16'd1);
    tx_done[1] = 1'b1;
    idle(1);
    tx_done[1] = 1'b0;
    idle(2);
    check("txd_fcnt2", fcnt[1], 16'd2);

    // Reset in the middle of a frame.
    send(0, 32'h55, 4'hF, 1'b0);
    send(0, 32'h56, 4'hF, 1'b0);
    rst_n = 1'b0;
    #1;
    check_zero(0);
    check_zero(1);
    idle(2);
    rst_n = 1'b1;
    #1;
    check("rel2_tready", s_tready[0], 1'b1);
    for (int i = 0; i < 4; i++) send(0, 32'h60 + W'(i), 4'hF, 1'b0);
    idle(10);
    check("post_rst_size", log_b.size(), 4);
    check("post_rst_first", log_b[0], {32'h60, 4'hF, 1'b0});
    check("post_rst_last", log_b[3], {32'h63, 4'hF, 1'b1});
    check("post_rst_fcnt", fcnt[0], 16'd1);

    // Random frames with random drain backpressure and tlast.
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          m_tready[0] = ($urandom_range(0, 3) != 0);
          m_tready[1] = ($urandom_range(0, 3) != 0);
          tx_done[1]  = ($urandom_range(0, 7) == 0);
          idle(1);
        end
      end
      begin
        for (int n = 0; n < 40; n++) begin
          send(0, $urandom, 4'($urandom), ($urandom_range(0, 4) == 0));
          send(1, $urandom, 4'($urandom), ($urandom_range(0, 4) == 0));
        end
      end
    join
    m_tready[0] = 1'b1;
    m_tready[1] = 1'b1;
    tx_done[1]  = 1'b1;
    idle(40);
    tx_done[1]  = 1'b0;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_pingpong_frame_buffer.md
# axis_pingpong_frame_buffer

Parametrised two-bank AXI-Stream frame buffer for the radar sample path: accepts a 32-bit (default) slave stream, collects samples into fixed-length frames, and replays each completed frame on a master stream with `tlast` on the final beat. It sits between the sample source and the DMA/transmit stage. While one frame drains, the next is captured without stalling. Banks are optionally held until the downstream stage confirms transmission with `tx_done`.

## Interface
- `C_AXIS_TDATA_WIDTH`, 32, data width in bits; a multiple of 8.
- `FRAME_LEN`, 256, beats per full frame; ≥2; `ADDR_W = $clog2(FRAME_LEN)`.
- `TX_DONE_RELEASE`, 1, 1 = bank freed only on `tx_done`; 0 = bank freed on the last master handshake.
- `axis_aclk` in 1: single clock for both streams.
- `axis_aresetn` in 1: asynchronous, active-low reset.
- `S_AXIS_tdata` in C_AXIS_TDATA_WIDTH: input sample.
- `S_AXIS_tstrb` in C_AXIS_TDATA_WIDTH/8: byte strobes, stored with the data.
- `S_AXIS_tlast` in 1: closes the current frame early (short frame).
- `S_AXIS_tvalid` in 1; `S_AXIS_tready` out 1.
- `M_AXIS_tdata` out C_AXIS_TDATA_WIDTH; `M_AXIS_tstrb` out C_AXIS_TDATA_WIDTH/8.
- `M_AXIS_tlast` out 1: high on the last beat of the stored frame.
- `M_AXIS_tvalid` out 1; `M_AXIS_tready` in 1.
- `tx_done` in 1: level or pulse; downstream transmit complete. Used only when `TX_DONE_RELEASE=1`.
- `frame_count` out 16: frames fully released; wraps at 2^16.

## Operation
- Storage is two banks of `FRAME_LEN` words. Each word is `{tstrb, tdata}`. Each bank stores a length register of `ADDR_W+1` bits.
- Per-bank state is EMPTY → FILLING → FULL → SENDING → (WAIT_DONE) → EMPTY.
- **Write side**
  - `wr_bank` pointer, reset 0.
  - `S_AXIS_tready` is high iff `state[wr_bank]` is EMPTY or FILLING. It is decoded combinationally from registered state.
  - Each accepted beat writes at `wr_cnt` and increments `wr_cnt`. EMPTY→FILLING on the first beat.
  - The frame closes on the accepted beat where `wr_cnt==FRAME_LEN-1` or `S_AXIS_tlast=1`. On close:
    - length ← `wr_cnt+1`
    - state ← FULL
    - `wr_cnt` ← 0
    - `wr_bank` toggles
  - A single-beat frame (tlast on beat 0) has length 1.
- **Read side**
  - `rd_bank` pointer, reset 0. When `state[rd_bank]==FULL`: state ← SENDING and `rd_cnt` ← 0.
  - The beat at `rd_cnt` is presented on M_AXIS. `M_AXIS_tlast = (rd_cnt == length-1)`.
  - A prefetch register feeds the registered RAM read, so throughput is 1 beat/cycle while `M_AXIS_tready` is high.
  - On the last handshake:
    - `TX_DONE_RELEASE=0`: state ← EMPTY, `frame_count`++, `rd_bank` toggles.
    - `TX_DONE_RELEASE=1`: state ← WAIT_DONE. The first cycle with `tx_done=1` sets state ← EMPTY, increments `frame_count` and toggles `rd_bank`.
  - `tx_done` in any other state is ignored. A `tx_done` already high in the cycle of the last handshake is not counted; only a sample from the following cycle onward counts.
- **Simultaneous events**
  - The write side closing one bank and the read side freeing the other in the same cycle both take effect.
  - A bank freed at edge k accepts data from cycle k+1.
- **Full condition**: with both banks FULL, SENDING or WAIT_DONE, `S_AXIS_tready=0`. No data is ever dropped.
- **Reset** (async assert, sync-released flops)
  - All banks EMPTY; all pointers and counters 0.
  - `S_AXIS_tready=0` while reset is asserted; it rises combinationally once the reset releases.
  - `M_AXIS_tvalid/tlast/tdata/tstrb` = 0; `frame_count` = 0.
  - A partial frame in progress is discarded.

## Timing
- Latency: first `M_AXIS_tvalid` is asserted 2 cycles after the handshake that closes a frame into an idle read side:
  - cycle +1: FULL→SENDING, RAM read issued
  - cycle +2: valid
- Once `M_AXIS_tvalid=1`, `tdata/tstrb/tlast` stay stable until the handshake. `tvalid` never drops without a handshake.
- Back-to-back frames:
  - `TX_DONE_RELEASE=0`: the next bank's first beat is valid 2 cycles after the previous last handshake.
  - `TX_DONE_RELEASE=1`: 2 cycles after `tx_done` is sampled.
- Sustained input rate: 1 beat/cycle, provided the drain keeps up.

## Structure
- Package `axis_buf_pkg` holds:
  - `bank_state_t` enum (EMPTY, FILLING, FULL, SENDING, WAIT_DONE)
  - `NUM_BANKS=2`
  - the frame-counter width constant (16)
- Sub-module `axis_buf_bank_ram`: simple dual-port RAM, one write port and one registered read port. It is instantiated per bank, or once with a bank-select MSB in the address.
- Top level contains the write FSM, the read FSM and the prefetch/output register.

## Test plan
Bench uses `FRAME_LEN=4`, 32-bit data.
- **Reset release, continuous input** `0x00000001..0x00000008` with tready=1, `TX_DONE_RELEASE=0` → output 1..4 with tlast on 4, then 5..8 with tlast on 8; first valid 2 cycles after beat 4 is accepted; `frame_count=2`.
- **Short frame**: beats `0xA`, `0xB` with tlast on `0xB` → output `0xA`, `0xB+tlast`; length 2; next frame starts at bank 1.
- **Backpressure**: `M_AXIS_tready=0` throughout, 12 input beats offered → 8 accepted, `S_AXIS_tready` low from beat 9; raising tready drains 8 beats in order with no gaps.
- **`TX_DONE_RELEASE=1`**: 4 beats sent, `tx_done` held low 20 cycles → bank stays WAIT_DONE and `frame_count=0`; one `tx_done` pulse → `frame_count=1` and bank writable next cycle.
- **Reset mid-frame**: assert `axis_aresetn=0` after 2 beats → all outputs 0 asynchronously; after release the partial data is never emitted.
- **Strobe integrity**: input tstrb `4'b0011` on beat 3 → the same strobe appears on output beat 3.
